obi_mem_responder: RTL and testbench
====================================

OBI_MEM_RESPONDER -- requirements
Module: obi_mem_responder

Interface
- REQ-001 SHALL have parameter BaseAddr, default 32'h1000_0000, byte address of word 0.
- REQ-002 SHALL have parameter NumWords, default 512, number of 32-bit words mapped (power of two, ≥2).
- REQ-003 SHALL have parameter WaitCycles, default 0, extra stall cycles between grant and SRAM access (0..15).
- REQ-004 SHALL have clk_i  in  1  single clock, all logic rising-edge.
- REQ-005 SHALL have rst_ni  in  1  reset, asynchronous and active-low.
- REQ-006 SHALL have req_i  in  1  initiator request.
- REQ-007 SHALL have gnt_o  out  1  request accepted this cycle.
- REQ-008 SHALL have addr_i  in  32  byte address.
- REQ-009 SHALL have we_i  in  1  1=write.
- REQ-010 SHALL have be_i  in  4  byte enables.
- REQ-011 SHALL have wdata_i  in  32  write data.
- REQ-012 SHALL have rvalid_o  out  1  response valid, one cycle, no backpressure.
- REQ-013 SHALL have rdata_o  out  32  read data.
- REQ-014 SHALL have err_o  out  1  error, qualified by rvalid_o.
- REQ-015 SHALL have sram_req_o  out  1  SRAM access strobe.
- REQ-016 SHALL have sram_we_o / sram_be_o / sram_addr_o / sram_wdata_o  out  1/4/$clog2(NumWords)/32  SRAM command; sram_addr_o is a word index.
- REQ-017 SHALL have sram_rdata_i  in  32  SRAM read data, valid the cycle after sram_req_o.
- REQ-018 SHALL have busy_o  out  1  high whenever state≠IDLE.

Function
- REQ-019 SHALL implement states IDLE, WAIT, ACCESS, RESP.
- REQ-020 SHALL drive gnt_o = req_i when state is IDLE or RESP, else 0 (combinational from req_i and state).
- REQ-021 SHALL, on grant, latch addr_i, we_i, be_i, wdata_i, and an in-range flag.
- REQ-022 SHALL treat an address as in range iff BaseAddr ≤ addr_i < BaseAddr+4*NumWords, evaluated in 33-bit unsigned arithmetic so the upper bound cannot wrap.
- REQ-023 SHALL ignore addr_i[1:0]; word index = (addr_i−BaseAddr)>>2.
- REQ-024 SHALL, on grant, go to WAIT if WaitCycles>0 (loading the counter with WaitCycles−1), else to ACCESS.
- REQ-025 SHALL decrement the counter in WAIT and move to ACCESS when it reaches 0.
- REQ-026 SHALL pulse sram_req_o for exactly one cycle in ACCESS, only if the request is in range and not a write with be==4'b0000, driving sram_* from the latched fields.
- REQ-027 SHALL keep sram_req_o=0 and sram_* outputs at 0 outside the ACCESS pulse.
- REQ-028 SHALL move ACCESS→RESP unconditionally.
- REQ-029 SHALL assert rvalid_o=1 for exactly one cycle in RESP.
- REQ-030 SHALL, in RESP, drive rdata_o=sram_rdata_i for in-range reads, 32'h0 for writes, and 32'hBADC_AB1E with err_o=1 for out-of-range accesses.
- REQ-031 SHALL force rdata_o=0 and err_o=0 whenever rvalid_o=0.
- REQ-032 SHALL, in RESP, go to WAIT/ACCESS per REQ-024 if a new request is granted in the same cycle, else to IDLE.
- REQ-033 SHALL give a grant-to-rvalid latency of WaitCycles+2 cycles and hold exactly one outstanding transaction.
- REQ-034 SHALL sustain back-to-back throughput of one transaction per WaitCycles+2 cycles.

Reset
- REQ-035 SHALL, on rst_ni low, immediately enter IDLE, clear the counter and latched fields, and drive gnt_o/rvalid_o/err_o/sram_req_o/busy_o=0, rdata_o=0 and sram_* outputs=0.
- REQ-036 SHALL abandon any in-flight transaction on reset mid-operation, with no rvalid_o afterwards for it.

Verification
- V-1: WaitCycles=0, read of 0x1000_0008 with SRAM word 2=0xCAFE_F00D -> gnt cycle 0, sram_req with addr 2 at cycle 1, rvalid with rdata 0xCAFE_F00D and err 0 at cycle 2.
- V-2: write of 0x1000_0004, be=4'b0101, data 0x1122_3344 -> sram_we=1, be=0101, addr=1 at cycle 1; rvalid with rdata 0 and err 0 at cycle 2.
- V-3: read of 0x1000_0800 (one past the end, NumWords=512) -> no sram_req; rvalid with err=1 and rdata 0xBADC_AB1E at cycle 2.
- V-4: WaitCycles=3, req held high for 3 reads -> grants at cycles 0, 5, 10; rvalid at cycles 5, 10, 15; gnt is 0 in WAIT and ACCESS.
- V-5: reset asserted in WAIT -> outputs are 0 immediately, no rvalid follows, and a fresh request after reset completes normally.
- V-6: write with be=0 -> no sram_req; rvalid with err=0.

Source files
------------

// File: rtl/obi_mem_responder.sv
// OBI-style single-outstanding memory responder in front of a synchronous
// single-port SRAM. Each granted request optionally stalls for WaitCycles,
// issues at most one SRAM strobe, then returns a single-cycle response.
module obi_mem_responder #(
    parameter logic [31:0] BaseAddr   = 32'h1000_0000,
    parameter int          NumWords   = 512,
    parameter int          WaitCycles = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        req_i,
    output logic                        gnt_o,
    input  logic [31:0]                 addr_i,
    input  logic                        we_i,
    input  logic [3:0]                  be_i,
    input  logic [31:0]                 wdata_i,
    output logic                        rvalid_o,
    output logic [31:0]                 rdata_o,
    output logic                        err_o,
    output logic                        sram_req_o,
    output logic                        sram_we_o,
    output logic [3:0]                  sram_be_o,
    output logic [$clog2(NumWords)-1:0] sram_addr_o,
    output logic [31:0]                 sram_wdata_o,
    input  logic [31:0]                 sram_rdata_i,
    output logic                        busy_o
);

    localparam int AW = $clog2(NumWords);

    // Range bounds held in 33 bits so a window ending at 2^32 does not wrap.
    localparam logic [32:0] LoAddr   = {1'b0, BaseAddr};
    localparam logic [32:0] HiAddr   = {1'b0, BaseAddr} + (33'(NumWords) << 2);
    localparam logic [3:0]  WaitLoad = (WaitCycles > 0) ? 4'(WaitCycles - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;

    // Fields captured at grant time
    logic [AW-1:0]   r_addr;
    logic            r_we;
    logic [3:0]      r_be;
    logic [31:0]     r_wdata;
    logic            r_inr;

    // Registered SRAM command and response strobe
    logic            r_sram_req;
    logic            r_sram_we;
    logic [3:0]      r_sram_be;
    logic [AW-1:0]   r_sram_addr;
    logic [31:0]     r_sram_wdata;
    logic            r_rvalid;

    logic            w_grant;
    logic            w_in_range;
    logic [31:0]     w_offset;
    logic [AW-1:0]   w_word;
    logic            w_fire_in;
    logic            w_fire_lat;
    logic            w_unused;

    // A new request can only be accepted when nothing is in flight or the
    // current one is retiring this cycle; reset blocks the grant outright.
    assign w_grant    = req_i & rst_ni & ((r_state == S_IDLE) | (r_state == S_RESP));

    assign w_in_range = ({1'b0, addr_i} >= LoAddr) && ({1'b0, addr_i} < HiAddr);
    assign w_offset   = addr_i - BaseAddr;
    assign w_word     = w_offset[AW+1:2];
    assign w_unused   = ^{w_offset[31:AW+2], w_offset[1:0]};

    // A write with no byte lanes enabled is a no-op, so the SRAM is not touched.
    assign w_fire_in  = w_in_range & ~(we_i & (be_i == 4'b0000));
    assign w_fire_lat = r_inr & ~(r_we & (r_be == 4'b0000));

    // Transaction sequencer: grant -> [WAIT] -> ACCESS -> RESP
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_be         <= 4'b0000;
            r_wdata      <= 32'h0;
            r_inr        <= 1'b0;
            r_sram_req   <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_be    <= 4'b0000;
            r_sram_addr  <= '0;
            r_sram_wdata <= 32'h0;
            r_rvalid     <= 1'b0;
        end else begin
            // SRAM command and response are single-cycle pulses by default
            r_sram_req   <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_be    <= 4'b0000;
            r_sram_addr  <= '0;
            r_sram_wdata <= 32'h0;
            r_rvalid     <= 1'b0;

            case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_grant) begin
                        r_addr  <= w_word;
                        r_we    <= we_i;
                        r_be    <= be_i;
                        r_wdata <= wdata_i;
                        r_inr   <= w_in_range;
                        if (WaitCycles > 0) begin
                            r_state <= S_WAIT;
                            r_cnt   <= WaitLoad;
                        end else begin
                            // No stall: the strobe comes straight from the bus
                            r_state <= S_ACCESS;
                            if (w_fire_in) begin
                                r_sram_req   <= 1'b1;
                                r_sram_we    <= we_i;
                                r_sram_be    <= be_i;
                                r_sram_addr  <= w_word;
                                r_sram_wdata <= wdata_i;
                            end
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_ACCESS;
                        if (w_fire_lat) begin
                            r_sram_req   <= 1'b1;
                            r_sram_we    <= r_we;
                            r_sram_be    <= r_be;
                            r_sram_addr  <= r_addr;
                            r_sram_wdata <= r_wdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACCESS: begin
                    r_state  <= S_RESP;
                    r_rvalid <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt_o        = w_grant;
    assign busy_o       = (r_state != S_IDLE);
    assign rvalid_o     = r_rvalid;
    assign err_o        = r_rvalid & ~r_inr;
    assign sram_req_o   = r_sram_req;
    assign sram_we_o    = r_sram_we;
    assign sram_be_o    = r_sram_be;
    assign sram_addr_o  = r_sram_addr;
    assign sram_wdata_o = r_sram_wdata;

    // Response data: SRAM read data lands in RESP, so it is muxed through
    // combinationally; everything is forced to zero outside the response.
    always_comb begin
        rdata_o = 32'h0;
        if (r_rvalid) begin
            if (!r_inr) begin
                rdata_o = 32'hBADC_AB1E;
            end else if (!r_we) begin
                rdata_o = sram_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: two instances (no stall / 3-cycle stall with a
// window ending exactly at 2^32), an SRAM emulation, and a word-level model.
module tb_obi_mem_responder;

    localparam logic [31:0] BASE0 = 32'h1000_0000;
    localparam logic [31:0] BASE1 = 32'hFFFF_FFC0;

    logic clk = 1'b0;
    logic rst_n;
    logic load_sram;

    logic [1:0]       req, we, gnt, rvalid, err, sreq, swe, busy;
    logic [1:0][31:0] addr, wdata, rdata, swdata, srdata;
    logic [1:0][3:0]  be, sbe;
    logic [8:0]       saddr0;
    logic [3:0]       saddr1;

    logic [31:0] sram0 [512];
    logic [31:0] sram1 [16];
    logic [31:0] ref0  [512];
    logic [31:0] ref1  [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    obi_mem_responder #(.BaseAddr(BASE0), .NumWords(512), .WaitCycles(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]),
        .addr_i(addr[0]), .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]),
        .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]),
        .sram_req_o(sreq[0]), .sram_we_o(swe[0]), .sram_be_o(sbe[0]),
        .sram_addr_o(saddr0), .sram_wdata_o(swdata[0]), .sram_rdata_i(srdata[0]),
        .busy_o(busy[0]));

    obi_mem_responder #(.BaseAddr(BASE1), .NumWords(16), .WaitCycles(3)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]),
        .addr_i(addr[1]), .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]),
        .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]),
        .sram_req_o(sreq[1]), .sram_we_o(swe[1]), .sram_be_o(sbe[1]),
        .sram_addr_o(saddr1), .sram_wdata_o(swdata[1]), .sram_rdata_i(srdata[1]),
        .busy_o(busy[1]));

    // Synchronous SRAM emulation: read data appears the cycle after the strobe
    always @(posedge clk) begin
        if (load_sram) begin
            for (int i = 0; i < 512; i++) sram0[i] <= ref0[i];
            for (int i = 0; i < 16; i++)  sram1[i] <= ref1[i];
        end else begin
            if (sreq[0]) begin
                if (swe[0]) begin
                    for (int b = 0; b < 4; b++)
                        if (sbe[0][b]) sram0[saddr0][8*b +: 8] <= swdata[0][8*b +: 8];
                end else begin
                    srdata[0] <= sram0[saddr0];
                end
            end
            if (sreq[1]) begin
                if (swe[1]) begin
                    for (int b = 0; b < 4; b++)
                        if (sbe[1][b]) sram1[saddr1][8*b +: 8] <= swdata[1][8*b +: 8];
                end else begin
                    srdata[1] <= sram1[saddr1];
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected summary");
        $fatal(1, "watchdog");
    end

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] get_saddr(input int d);
        return (d == 1) ? {28'b0, saddr1} : {23'b0, saddr0};
    endfunction

    function automatic logic [31:0] ref_rd(input int d, input int idx);
        return (d == 1) ? ref1[idx] : ref0[idx];
    endfunction

    task automatic ref_wr(input int d, input int idx, input logic [3:0] b, input logic [31:0] wd);
        logic [31:0] v;
        v = ref_rd(d, idx);
        for (int i = 0; i < 4; i++)
            if (b[i]) v[8*i +: 8] = wd[8*i +: 8];
        if (d == 1) ref1[idx] = v;
        else        ref0[idx] = v;
    endtask

    // One transaction with cycle-exact checks; called at a negedge (+ small
    // offset), returns just after the negedge of its response cycle.
    task automatic do_txn(input int d, input logic [31:0] a, input logic w,
                          input logic [3:0] b, input logic [31:0] wd);
        int              wc;
        longint unsigned base, nw, ea;
        bit              inr, fire;
        int              idx;
        logic [31:0]     expd;
        wc   = (d == 1) ? 3 : 0;
        base = (d == 1) ? 64'(BASE1) : 64'(BASE0);
        nw   = (d == 1) ? 16 : 512;
        ea   = 64'(a);
        inr  = (ea >= base) && (ea < base + 4 * nw);
        idx  = inr ? int'((ea - base) / 4) : 0;
        fire = inr && !(w && (b == 4'b0000));
        expd = !inr ? 32'hBADC_AB1E : (w ? 32'h0 : ref_rd(d, idx));

        req[d] = 1'b1; addr[d] = a; we[d] = w; be[d] = b; wdata[d] = wd;
        #1;
        chk1("gnt", gnt[d], 1'b1);
        @(negedge clk);
        req[d] = 1'b0;
        for (int k = 1; k <= wc + 2; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            if (k <= wc) begin
                chk1("wait_sreq", sreq[d], 1'b0);
                chk32("wait_saddr", get_saddr(d), 32'h0);
                chk1("wait_busy", busy[d], 1'b1);
                chk1("wait_rvalid", rvalid[d], 1'b0);
            end else if (k == wc + 1) begin
                chk1("acc_sreq", sreq[d], fire);
                chk1("acc_rvalid", rvalid[d], 1'b0);
                chk1("acc_gnt", gnt[d], 1'b0);
                if (fire) begin
                    chk32("acc_saddr", get_saddr(d), 32'(idx));
                    chk1("acc_swe", swe[d], w);
                    chk32("acc_sbe", 32'(sbe[d]), 32'(b));
                    if (w) chk32("acc_swdata", swdata[d], wd);
                end else begin
                    chk1("acc_swe0", swe[d], 1'b0);
                    chk32("acc_sbe0", 32'(sbe[d]), 32'h0);
                    chk32("acc_saddr0", get_saddr(d), 32'h0);
                end
            end else begin
                chk1("resp_rvalid", rvalid[d], 1'b1);
                chk32("resp_rdata", rdata[d], expd);
                chk1("resp_err", err[d], !inr);
                chk1("resp_busy", busy[d], 1'b1);
                chk1("resp_sreq", sreq[d], 1'b0);
            end
        end
        if (inr && w) ref_wr(d, idx, b, wd);
    endtask

    task automatic idle(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            chk1("idle_rvalid", rvalid[d], 1'b0);
            chk1("idle_err", err[d], 1'b0);
            chk32("idle_rdata", rdata[d], 32'h0);
            chk1("idle_busy", busy[d], 1'b0);
            chk1("idle_sreq", sreq[d], 1'b0);
        end
    endtask

    initial begin
        int          gi;
        int          d, cat;
        logic [31:0] a, wd;
        logic        w;
        logic [3:0]  b;
        longint unsigned base, span;

        rst_n = 1'b0;
        load_sram = 1'b1;
        req = '0; we = '0; be = '0; addr = '0; wdata = '0;
        for (int i = 0; i < 512; i++) ref0[i] = $urandom;
        for (int i = 0; i < 16; i++)  ref1[i] = $urandom;
        ref0[2] = 32'hCAFE_F00D;

        // Reset state, with requests pending so the grant gating is visible
        @(posedge clk);
        @(posedge clk);
        req = 2'b11;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk1("rst_gnt", gnt[i], 1'b0);
            chk1("rst_rvalid", rvalid[i], 1'b0);
            chk1("rst_err", err[i], 1'b0);
            chk32("rst_rdata", rdata[i], 32'h0);
            chk1("rst_sreq", sreq[i], 1'b0);
            chk1("rst_busy", busy[i], 1'b0);
            chk32("rst_saddr", get_saddr(i), 32'h0);
        end
        @(negedge clk);
        req = '0;
        load_sram = 1'b0;
        rst_n = 1'b1;
        #1;

        // Directed: read, partial write, one-past-end, empty write, readbacks
        do_txn(0, 32'h1000_0008, 1'b0, 4'hF, 32'h0);
        do_txn(0, 32'h1000_0004, 1'b1, 4'b0101, 32'h1122_3344);
        do_txn(0, 32'h1000_0800, 1'b0, 4'hF, 32'h0);
        idle(0, 1);
        do_txn(0, 32'h1000_0010, 1'b1, 4'b0000, 32'hDEAD_BEEF);
        do_txn(0, 32'h1000_0005, 1'b0, 4'hF, 32'h0);
        do_txn(0, 32'h1000_0012, 1'b0, 4'hF, 32'h0);
        do_txn(0, 32'h0FFF_FFFC, 1'b0, 4'hF, 32'h0);
        do_txn(0, 32'h1000_07FC, 1'b0, 4'hF, 32'h0);
        idle(0, 2);

        // Window reaching the top of the address space
        do_txn(1, 32'hFFFF_FFFF, 1'b0, 4'hF, 32'h0);
        do_txn(1, 32'hFFFF_FFBF, 1'b0, 4'hF, 32'h0);
        do_txn(1, 32'h0000_0000, 1'b0, 4'hF, 32'h0);
        do_txn(1, 32'hFFFF_FFC0, 1'b1, 4'b1000, 32'hA5A5_A5A5);
        idle(1, 1);

        // Back-to-back reads with req held high, 3-cycle stall
        gi = 0;
        req[1] = 1'b1; addr[1] = BASE1; we[1] = 1'b0; be[1] = 4'hF;
        for (int c = 0; c <= 16; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (c == 1 || c == 6 || c == 11) begin
                    gi++;
                    if (gi < 3) addr[1] = BASE1 + 32'(4 * gi);
                    else        req[1] = 1'b0;
                end
            end
            #1;
            chk1("b2b_gnt", gnt[1], (c == 0 || c == 5 || c == 10));
            chk1("b2b_rvalid", rvalid[1], (c == 5 || c == 10 || c == 15));
            chk1("b2b_sreq", sreq[1], (c == 4 || c == 9 || c == 14));
            chk1("b2b_busy", busy[1], (c >= 1 && c <= 15));
            if (c == 5 || c == 10 || c == 15)
                chk32("b2b_rdata", rdata[1], ref1[c / 5 - 1]);
        end

        // Reset while stalled: the write is abandoned
        req[1] = 1'b1; addr[1] = BASE1 + 32'd8; we[1] = 1'b1; be[1] = 4'hF;
        wdata[1] = 32'h0BAD_0BAD;
        @(negedge clk);
        req[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        req[1] = 1'b1;
        #1;
        chk1("mid_rst_busy", busy[1], 1'b0);
        chk1("mid_rst_gnt", gnt[1], 1'b0);
        chk1("mid_rst_rvalid", rvalid[1], 1'b0);
        chk32("mid_rst_rdata", rdata[1], 32'h0);
        chk1("mid_rst_sreq", sreq[1], 1'b0);
        @(negedge clk);
        req[1] = 1'b0;
        rst_n = 1'b1;
        #1;
        idle(1, 6);
        do_txn(1, BASE1 + 32'd8, 1'b0, 4'hF, 32'h0);
        idle(1, 1);

        // Randomized traffic on both instances
        for (int i = 0; i < 80; i++) begin
            d    = $urandom_range(0, 1);
            base = (d == 1) ? 64'(BASE1) : 64'(BASE0);
            span = (d == 1) ? 64 : 2048;
            cat  = $urandom_range(0, 5);
            case (cat)
                0:       a = 32'(base + span + $urandom_range(0, 15));
                1:       a = 32'(base - 1 - $urandom_range(0, 15));
                2:       a = $urandom;
                default: a = 32'(base + $urandom_range(0, 32'(span) - 1));
            endcase
            w  = 1'($urandom_range(0, 1));
            b  = 4'($urandom);
            if ($urandom_range(0, 7) == 0) b = 4'b0000;
            wd = $urandom;
            do_txn(d, a, w, b, wd);
            if ($urandom_range(0, 3) == 0) idle(d, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
